// File: rtl/seq_pkg.sv
// Shared definitions for the sequence checker: flag bit positions,
// checker FSM states and a saturating-increment helper.
package seq_pkg;

  localparam int unsigned MF_V   = 0;
  localparam int unsigned MF_L   = 1;
  localparam int unsigned MF_F   = 2;
  localparam int unsigned MF_A   = 3;
  localparam int unsigned SF_BSY = 0;
  localparam int unsigned SF_ERR = 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? top : v + 64'd1;
  endfunction

endpackage

// File: rtl/seq_chk_if.sv
// Upstream stream link: data and master flags toward the sink,
// slave flags (busy/error) back to the source.
interface seq_chk_if #(parameter int unsigned W = 16);
  logic [W-1:0] uc_d0;
  logic [3:0]   uc_mflags;
  logic [1:0]   cu_sflags;

  modport master (output uc_d0, output uc_mflags, input cu_sflags);
  modport slave  (input uc_d0, input uc_mflags, output cu_sflags);
endinterface

// File: rtl/skid_fifo2.sv
// Two-entry FIFO. A push into a full FIFO is ignored unless a pop happens
// in the same cycle; occ_next exposes the occupancy after this cycle.
module skid_fifo2 #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [1:0]    occ_next
);

  logic [DW-1:0] mem [2];
  logic          rd_ptr;
  logic          wr_ptr;
  logic [1:0]    occ;
  logic          do_push;
  logic          do_pop;

  assign full     = (occ == 2'd2);
  assign empty    = (occ == 2'd0);
  assign pop_data = mem[rd_ptr];

  // Qualify push/pop against occupancy and derive the next occupancy.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    unique case ({do_push, do_pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ_next;
    end
  end

endmodule

// File: rtl/seq_chk.sv
// Stream sink: buffers incoming beats in a 2-entry FIFO and checks them
// against an incrementing cnt_ini..cnt_max sequence with first/last framing.
module seq_chk
  import seq_pkg::*;
#(
  parameter int unsigned W  = 16,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  cnt_ini,
  input  logic [W-1:0]  cnt_max,
  seq_chk_if.slave      uc,
  input  logic          sink_rdy,
  output logic          frm_done,
  output logic [CW-1:0] frm_cnt,
  output logic [CW-1:0] beat_cnt,
  output logic [CW-1:0] err_cnt,
  output logic [W-1:0]  err_exp,
  output logic [W-1:0]  err_got,
  output logic          ovf
);

  localparam int unsigned QW = W + 3;

  function automatic logic [CW-1:0] cw_inc(input logic [CW-1:0] v);
    logic [63:0] t;
    t = sat_inc(64'(v), CW);
    return t[CW-1:0];
  endfunction

  logic          acc;
  logic          pop;
  logic          full;
  logic          empty;
  logic [1:0]    occ_next;
  logic [QW-1:0] q_out;
  logic          ovf_evt;

  logic          b_a;
  logic          b_f;
  logic          b_l;
  logic [W-1:0]  b_d;

  state_t        state;
  state_t        state_n;
  logic [W-1:0]  exp_val;
  logic [W-1:0]  exp_n;
  logic          frame_ok;
  logic          ok_n;
  logic          counted;
  logic          beat_err;
  logic          mis;
  logic          chk_bad;
  logic          need_l;
  logic          done_n;
  logic [W-1:0]  want;
  logic [CW-1:0] err_step;

  logic          bsy;
  logic          err_flag;

  assign acc     = uc.uc_mflags[MF_V];
  assign pop     = sink_rdy && !empty;
  assign ovf_evt = acc && full && !pop;

  skid_fifo2 #(.DW(QW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (acc),
    .push_data ({uc.uc_mflags[MF_A], uc.uc_mflags[MF_F], uc.uc_mflags[MF_L], uc.uc_d0}),
    .pop       (pop),
    .pop_data  (q_out),
    .full      (full),
    .empty     (empty),
    .occ_next  (occ_next)
  );

  assign b_d = q_out[W-1:0];
  assign b_l = q_out[W];
  assign b_f = q_out[W+1];
  assign b_a = q_out[W+2];

  assign uc.cu_sflags[SF_BSY] = bsy;
  assign uc.cu_sflags[SF_ERR] = err_flag;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Next state and per-beat check of the beat leaving the FIFO.
  // A first-flag beat restarts the frame: its own unexpected-F error is
  // counted but does not taint the frame it opens.
  always_comb begin
    state_n  = state;
    exp_n    = exp_val;
    ok_n     = frame_ok;
    counted  = 1'b0;
    beat_err = 1'b0;
    mis      = 1'b0;
    chk_bad  = 1'b0;
    need_l   = 1'b0;
    done_n   = 1'b0;
    want     = exp_val;
    if (pop) begin
      if (b_a) begin
        state_n = ST_IDLE;
      end else begin
        counted = 1'b1;
        if (state == ST_IDLE && !b_f) begin
          beat_err = 1'b1;
        end else begin
          want     = b_f ? cnt_ini : exp_val;
          need_l   = (b_d == cnt_max) || (cnt_ini >= cnt_max);
          mis      = (b_d != want);
          chk_bad  = mis || (b_l != need_l);
          beat_err = chk_bad || (state == ST_FRAME && b_f);
          ok_n     = (b_f || frame_ok) && !chk_bad;
          exp_n    = b_d + W'(1);
          if (b_l) begin
            state_n = ST_IDLE;
            done_n  = ok_n;
          end else begin
            state_n = ST_FRAME;
          end
        end
      end
    end
  end

  // Error counter may take one check error and one overflow in the same cycle.
  always_comb begin
    err_step = beat_err ? cw_inc(err_cnt) : err_cnt;
    if (ovf_evt) err_step = cw_inc(err_step);
  end

  // Registered check results, statistics and flow-control flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_val  <= '0;
      frame_ok <= 1'b0;
      frm_done <= 1'b0;
      frm_cnt  <= '0;
      beat_cnt <= '0;
      err_cnt  <= '0;
      err_exp  <= '0;
      err_got  <= '0;
      ovf      <= 1'b0;
      bsy      <= 1'b0;
      err_flag <= 1'b0;
    end else begin
      exp_val  <= exp_n;
      frame_ok <= ok_n;
      frm_done <= done_n;
      if (done_n)  frm_cnt  <= cw_inc(frm_cnt);
      if (counted) beat_cnt <= cw_inc(beat_cnt);
      err_cnt <= err_step;
      if (mis) begin
        err_exp <= want;
        err_got <= b_d;
      end
      if (ovf_evt) ovf <= 1'b1;
      if (beat_err || ovf_evt) err_flag <= 1'b1;
      bsy <= (occ_next != 2'd0);
    end
  end

endmodule

// File: tb/tb_seq_chk.sv
// Self-checking bench for seq_chk: directed scenarios plus a randomized
// stream compared against a queue-based reference model.
module tb_seq_chk;

  typedef struct {
    bit          a;
    bit          f;
    bit          l;
    logic [15:0] d;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] cnt_ini = 16'd1;
  logic [15:0] cnt_max = 16'd15;
  logic        sink_rdy = 1'b0;
  logic        frm_done;
  logic [15:0] frm_cnt;
  logic [15:0] beat_cnt;
  logic [15:0] err_cnt;
  logic [15:0] err_exp;
  logic [15:0] err_got;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;

  // reference model state
  beat_t       q[$];
  bit          m_in_frame;
  bit          m_ok;
  logic [15:0] m_exp;
  int          m_frm, m_beat, m_err;
  logic [15:0] m_eexp, m_egot;
  bit          m_ovf, m_errf, m_done, m_bsy;

  seq_chk_if #(.W(16)) uc_if ();

  seq_chk #(.W(16), .CW(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .cnt_ini  (cnt_ini),
    .cnt_max  (cnt_max),
    .uc       (uc_if),
    .sink_rdy (sink_rdy),
    .frm_done (frm_done),
    .frm_cnt  (frm_cnt),
    .beat_cnt (beat_cnt),
    .err_cnt  (err_cnt),
    .err_exp  (err_exp),
    .err_got  (err_got),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic model_clear();
    q.delete();
    m_in_frame = 0; m_ok = 0; m_exp = '0;
    m_frm = 0; m_beat = 0; m_err = 0;
    m_eexp = '0; m_egot = '0;
    m_ovf = 0; m_errf = 0; m_done = 0; m_bsy = 0;
  endtask

  // Apply the checking rules to one beat taken from the buffer.
  task automatic model_check(input beat_t b);
    logic [15:0] want;
    bit need_l, bad;
    if (b.a) begin
      m_in_frame = 0;
      return;
    end
    m_beat = sat16(m_beat);
    if (!m_in_frame && !b.f) begin
      m_err = sat16(m_err); m_errf = 1;
      return;
    end
    if (b.f) begin want = cnt_ini; m_ok = 1; end
    else want = m_exp;
    bad = 0;
    if (b.d != want) begin bad = 1; m_eexp = want; m_egot = b.d; end
    need_l = (b.d == cnt_max) || (cnt_ini >= cnt_max);
    if (b.l != need_l) bad = 1;
    if (bad || (m_in_frame && b.f)) begin m_err = sat16(m_err); m_errf = 1; end
    if (bad) m_ok = 0;
    m_exp = b.d + 16'd1;
    if (b.l) begin
      if (m_ok) begin m_done = 1; m_frm = sat16(m_frm); end
      m_in_frame = 0;
    end else begin
      m_in_frame = 1;
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, settle.
  task automatic cycle(input bit v, input bit a, input bit f, input bit l,
                       input logic [15:0] d, input bit rdy);
    beat_t nb, pb;
    bit popping;
    uc_if.uc_d0     = d;
    uc_if.uc_mflags = {a, f, l, v};
    sink_rdy        = rdy;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      m_done  = 0;
      popping = (q.size() > 0) && rdy;
      if (popping) begin
        pb = q.pop_front();
        model_check(pb);
      end
      if (v) begin
        nb.a = a; nb.f = f; nb.l = l; nb.d = d;
        if (q.size() < 2) q.push_back(nb);
        else begin m_ovf = 1; m_errf = 1; m_err = sat16(m_err); end
      end
      m_bsy = (q.size() > 0);
    end
    #1;
    if (frm_done === 1'b1) done_seen++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 16'd0, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(0, 0, 0, 0, 16'd0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({frm_done, frm_cnt, beat_cnt, err_cnt, err_exp, err_got, ovf, uc_if.cu_sflags} !== 84'd0) begin
      errors++;
      $display("FAIL reset_outputs got done=%0b frm=%0d beat=%0d err=%0d exp=%0h got=%0h ovf=%0b sflags=%b want all 0",
               frm_done, frm_cnt, beat_cnt, err_cnt, err_exp, err_got, ovf, uc_if.cu_sflags);
    end
  endtask

  task automatic test_clean_frame();
    do_reset();
    cnt_ini = 16'd1; cnt_max = 16'd15;
    for (int i = 1; i <= 15; i++)
      cycle(1, 0, i == 1, i == 15, 16'(i), 1);
    checks++;
    if (frm_done !== 1'b0) begin errors++; $display("FAIL clean_done_early got %b want 0", frm_done); end
    idle(1);
    checks++;
    if (frm_done !== 1'b1) begin errors++; $display("FAIL clean_done_pulse got %b want 1", frm_done); end
    checks++;
    if (frm_cnt !== 16'd1 || beat_cnt !== 16'd15 || err_cnt !== 16'd0 || uc_if.cu_sflags[1] !== 1'b0) begin
      errors++;
      $display("FAIL clean_counts got frm=%0d beat=%0d err=%0d errflag=%b want 1 15 0 0",
               frm_cnt, beat_cnt, err_cnt, uc_if.cu_sflags[1]);
    end
    idle(1);
    checks++;
    if (frm_done !== 1'b0) begin errors++; $display("FAIL clean_done_width got %b want 0", frm_done); end
  endtask

  task automatic test_mismatch();
    do_reset();
    done_seen = 0;
    for (int i = 1; i <= 15; i++) begin
      cycle(1, 0, i == 1, i == 15, (i == 7) ? 16'd9 : 16'(i), 1);
      if (i == 8) begin
        checks++;
        if (err_cnt !== 16'd1 || err_exp !== 16'd7 || err_got !== 16'd9) begin
          errors++;
          $display("FAIL mismatch_first got err=%0d exp=%0d got=%0d want 1 7 9", err_cnt, err_exp, err_got);
        end
      end
    end
    idle(2);
    checks++;
    if (err_cnt !== 16'd2 || err_exp !== 16'd10 || err_got !== 16'd8) begin
      errors++;
      $display("FAIL mismatch_resync got err=%0d exp=%0d got=%0d want 2 10 8", err_cnt, err_exp, err_got);
    end
    checks++;
    if (done_seen != 0 || frm_cnt !== 16'd0 || uc_if.cu_sflags[1] !== 1'b1) begin
      errors++;
      $display("FAIL mismatch_no_done got pulses=%0d frm=%0d errflag=%b want 0 0 1", done_seen, frm_cnt, uc_if.cu_sflags[1]);
    end
  endtask

  task automatic test_backpressure();
    int  nxt;
    bit  bsy_prev, sent;
    do_reset();
    nxt = 1; bsy_prev = 0;
    for (int c = 0; c < 300 && (nxt <= 15 || q.size() > 0); c++) begin
      sent = (nxt <= 15) && !bsy_prev;
      bsy_prev = uc_if.cu_sflags[0];
      if (sent) begin
        cycle(1, 0, nxt == 1, nxt == 15, 16'(nxt), (c % 4) == 0);
        nxt++;
      end else begin
        cycle(0, 0, 0, 0, 16'd0, (c % 4) == 0);
      end
    end
    idle(2);
    checks++;
    if (nxt != 16 || q.size() != 0) begin
      errors++;
      $display("FAIL bp_timeout got sent=%0d pending=%0d want 15 0", nxt - 1, q.size());
    end
    checks++;
    if (ovf !== 1'b0 || frm_cnt !== 16'd1 || beat_cnt !== 16'd15 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL bp_result got ovf=%b frm=%0d beat=%0d err=%0d want 0 1 15 0", ovf, frm_cnt, beat_cnt, err_cnt);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    cycle(1, 0, 1, 0, 16'd1, 0);
    cycle(1, 0, 0, 0, 16'd2, 0);
    cycle(1, 0, 0, 0, 16'd3, 0);
    checks++;
    if (ovf !== 1'b1 || err_cnt !== 16'd1 || uc_if.cu_sflags !== 2'b11) begin
      errors++;
      $display("FAIL ovf_flag got ovf=%b err=%0d sflags=%b want 1 1 11", ovf, err_cnt, uc_if.cu_sflags);
    end
    idle(3);
    checks++;
    if (beat_cnt !== 16'd2 || err_cnt !== 16'd1 || uc_if.cu_sflags[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drain got beat=%0d err=%0d bsy=%b want 2 1 0", beat_cnt, err_cnt, uc_if.cu_sflags[0]);
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int i = 1; i <= 5; i++) cycle(1, 0, i == 1, 0, 16'(i), 1);
    cycle(1, 1, 0, 0, 16'd0, 1);
    for (int i = 1; i <= 15; i++) cycle(1, 0, i == 1, i == 15, 16'(i), 1);
    idle(2);
    checks++;
    if (err_cnt !== 16'd0 || frm_cnt !== 16'd1 || uc_if.cu_sflags[1] !== 1'b0) begin
      errors++;
      $display("FAIL abort_result got err=%0d frm=%0d errflag=%b want 0 1 0", err_cnt, frm_cnt, uc_if.cu_sflags[1]);
    end
  endtask

  task automatic test_degenerate_reset();
    do_reset();
    cnt_ini = 16'd4; cnt_max = 16'd4;
    cycle(1, 0, 1, 1, 16'd4, 1);
    idle(1);
    checks++;
    if (frm_cnt !== 16'd1 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL degen_frame got frm=%0d err=%0d want 1 0", frm_cnt, err_cnt);
    end
    cnt_ini = 16'd1; cnt_max = 16'd15;
    for (int i = 1; i <= 3; i++) cycle(1, 0, i == 1, 0, 16'(i), 0);
    rst = 1'b1;
    cycle(1, 0, 0, 0, 16'd4, 1);
    rst = 1'b0;
    checks++;
    if ({frm_done, frm_cnt, beat_cnt, err_cnt, err_exp, err_got, ovf, uc_if.cu_sflags} !== 84'd0) begin
      errors++;
      $display("FAIL midframe_reset got done=%0b frm=%0d beat=%0d err=%0d ovf=%0b sflags=%b want all 0",
               frm_done, frm_cnt, beat_cnt, err_cnt, ovf, uc_if.cu_sflags);
    end
    for (int i = 1; i <= 15; i++) cycle(1, 0, i == 1, i == 15, 16'(i), 1);
    idle(2);
    checks++;
    if (frm_cnt !== 16'd1 || err_cnt !== 16'd0 || beat_cnt !== 16'd15) begin
      errors++;
      $display("FAIL post_reset_frame got frm=%0d err=%0d beat=%0d want 1 0 15", frm_cnt, err_cnt, beat_cnt);
    end
  endtask

  task automatic test_random();
    beat_t stim[$];
    beat_t b;
    int    n, r;
    bit    bsy_prev, send;
    logic [83:0] want, got;
    do_reset();
    cnt_ini = 16'($urandom_range(0, 5));
    cnt_max = cnt_ini + 16'($urandom_range(0, 6));
    n = (cnt_ini >= cnt_max) ? 1 : int'(cnt_max - cnt_ini) + 1;
    for (int fr = 0; fr < 40; fr++) begin
      for (int i = 0; i < n; i++) begin
        b.a = 0; b.f = (i == 0); b.l = (i == n - 1); b.d = cnt_ini + 16'(i);
        r = int'($urandom_range(0, 99));
        if (r < 6) b.d = b.d ^ 16'(1 << $urandom_range(0, 3));
        else if (r < 9) b.l = ~b.l;
        else if (r < 12) b.f = ~b.f;
        else if (r < 14) b.a = 1;
        stim.push_back(b);
        if (b.a) break;
      end
    end
    bsy_prev = 0;
    for (int c = 0; c < 6000 && (stim.size() > 0 || q.size() > 0); c++) begin
      send = (stim.size() > 0) && (!bsy_prev || $urandom_range(0, 19) == 0);
      bsy_prev = m_bsy;
      if (send) begin
        b = stim.pop_front();
        cycle(1, b.a, b.f, b.l, b.d, $urandom_range(0, 3) != 0);
      end else begin
        cycle(0, 0, 0, 0, 16'($urandom), $urandom_range(0, 3) != 0);
      end
      want = {m_done, 16'(m_frm), 16'(m_beat), 16'(m_err), m_eexp, m_egot, m_ovf, m_errf, m_bsy};
      got  = {frm_done, frm_cnt, beat_cnt, err_cnt, err_exp, err_got, ovf, uc_if.cu_sflags};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL random_cycle%0d got %h want %h", c, got, want);
      end
    end
    checks++;
    if (stim.size() != 0 || q.size() != 0) begin
      errors++;
      $display("FAIL random_timeout got pending=%0d want 0", stim.size() + q.size());
    end
  endtask

  initial begin
    uc_if.uc_d0     = '0;
    uc_if.uc_mflags = '0;
    model_clear();
    test_reset();
    test_clean_frame();
    test_mismatch();
    test_backpressure();
    test_overflow();
    test_abort();
    test_degenerate_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_chk.md
Name: seq_chk

Overview:
- Stream sink and checker; the receiving end of the gen_seq stream protocol.
- Accepts beats on the uc_d0/uc_mflags upstream interface and returns flow control on cu_sflags.
- Buffers beats in a 2-entry skid FIFO, then checks them against an incrementing sequence cnt_ini..cnt_max with correct first/last framing.
- Serves as the end-of-chain scoreboard for gen_seq- and fir-based pipelines.

Parameters:
- W, 16, data width of uc_d0, cnt_ini, cnt_max and the expected-value register.
- CW, 16, width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cnt_ini  in  W  first value of each frame; sampled whenever a frame starts.
- cnt_max  in  W  last value of each frame.
- uc_d0  in  W  upstream data.
- uc_mflags  in  4  {A,F,L,V}: [3] abort, [2] first, [1] last, [0] valid.
- cu_sflags  out  2  {ERR,BSY}: [1] sticky error, [0] busy/hold to upstream.
- sink_rdy  in  1  permits a FIFO pop toward the checker in the current cycle.
- frm_done  out  1  one-cycle pulse when a frame closes correctly.
- frm_cnt  out  CW  frames closed correctly, saturating.
- beat_cnt  out  CW  beats checked, saturating.
- err_cnt  out  CW  error events, saturating.
- err_exp  out  W  expected value at the most recent data mismatch.
- err_got  out  W  received value at the most recent data mismatch.
- ovf  out  1  sticky: a beat arrived while the FIFO was full.

Behaviour:
- Reset: all outputs 0, FIFO empty, FSM in IDLE, expected value 0. Reset takes effect mid-frame the same way.
- Accept: a beat is accepted in cycle N when V=1. It is written to the FIFO in cycle N.
- Busy: cu_sflags[0] is a register, set from the next FIFO occupancy ≥ 1. Upstream samples BSY and holds, so at most one beat arrives after BSY rises.
- Overflow: V=1 with the FIFO full drops the beat and sets ovf and ERR.
- Simultaneous push and pop on a full FIFO is legal and is not an overflow.
- Pop: occurs when the FIFO is non-empty and sink_rdy=1. The check result and all counters are registered, so they update in cycle pop+1.
- Minimum latency: accept → frm_done is 2 cycles.
- FSM state IDLE:
  - A beat with F=1 starts a frame: expected = cnt_ini; the value is checked; go to FRAME.
  - A beat without F is an error; stay in IDLE.
  - A=1 beats are discarded silently.
- FSM state FRAME:
  - Each beat is checked against expected; then expected = got+1, modulo 2^W, so the checker resyncs after a mismatch.
  - L is required iff got == cnt_max.
  - A beat with L=1 and all checks of the frame passed pulses frm_done and increments frm_cnt.
  - Any beat with L=1 returns to IDLE.
  - F=1 inside a frame counts one error and restarts the frame from that beat.
  - A=1 returns to IDLE with no error and no count.
- Error events (err_cnt +1 each, at most 1 per beat; ERR set sticky):
  - data mismatch, which also loads err_exp and err_got;
  - L missing or spurious;
  - F missing or unexpected;
  - overflow.
- Degenerate config cnt_ini ≥ cnt_max: a frame is a single beat with F=L=1 and value cnt_ini.
- Counters stop at all-ones; no wrap.
- Same-cycle accept, pop and check of different beats are independent.

Decomposition:
- Shared package seq_pkg:
  - flag bit indices MF_V=0, MF_L=1, MF_F=2, MF_A=3, SF_BSY=0, SF_ERR=1;
  - FSM state encoding (IDLE, FRAME);
  - saturating-increment function.
- One sub-module, skid_fifo2: parameterized 2-entry FIFO with push/pop/full/empty and next-occupancy output. It is reused later by gen_seq's busy path.

Test Plan:
- Clean frame, W=16, cnt_ini=1, cnt_max=15, beats 1..15 with F on 1 and L on 15, sink_rdy=1 → frm_done pulse 2 cycles after beat 15; frm_cnt=1, beat_cnt=15, err_cnt=0, cu_sflags[1]=0.
- Data mismatch: same frame with 7 replaced by 9 → err_cnt=1, err_exp=7, err_got=9. Next expected is 10, so beat 8 also errors: err_cnt=2; frm_done not pulsed.
- Backpressure: sink_rdy toggles 1-of-4, upstream honours BSY → no ovf; all 15 beats checked in order; frm_cnt=1.
- Overflow: sink_rdy=0 and upstream ignores BSY, sending 3 beats → ovf=1, err_cnt=1, FIFO holds the first 2 beats.
- Abort: send 1..5, then a beat with A=1, then a clean 1..15 frame → err_cnt=0, frm_cnt=1.
- Degenerate config and reset: cnt_ini=cnt_max=4, single beat with F=L=1, value 4 → frm_cnt=1. Then rst pulsed mid-frame → all outputs 0 the next cycle; BSY=0.
